if_branch_predictor_dynamic: RTL

//  Dynamic conditional-branch predictor for the IF stage; successor to the static predictor.

---
 rtl/if_branch_predictor_dynamic.sv | 137 +++++++++++++
 1 files changed

// File: rtl/if_branch_predictor_dynamic.sv
// Dynamic conditional-branch predictor for the IF stage.
// Holds a PC-indexed table of saturating counters. An in-flight FIFO pairs each
// ID-stage prediction with its later EX-stage outcome. Counters train in program
// order. Mispredicts discard wrong-path entries, and hit/miss statistics are kept.
module if_branch_predictor_dynamic #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int INIT_CTR   = 1,
  parameter int QDEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       predict_valid,
  input  logic [PC_WIDTH-1:0]        predict_pc,
  output logic                       predict_take,
  output logic                       predict_ready,
  input  logic                       feedback_valid,
  input  logic                       feedback_take,
  output logic                       feedback_mispredict,
  input  logic                       flush,
  output logic [$clog2(QDEPTH):0]    inflight_count,
  output logic [15:0]                hit_count,
  output logic [15:0]                miss_count,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam int ENTRIES = 2 ** INDEX_BITS;
  localparam int PTR_W   = $clog2(QDEPTH);
  localparam int CNT_W   = PTR_W + 1;

  // Prediction table and in-flight queue storage
  logic [CTR_BITS-1:0]   ctr_tab [ENTRIES];
  logic [INDEX_BITS-1:0] q_idx   [QDEPTH];
  logic                  q_pred  [QDEPTH];

  logic [PTR_W-1:0]      head, tail;
  logic [CNT_W-1:0]      count;

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] head_idx;
  logic                  head_pred;
  logic                  empty, full, pop, push, discard;
  logic                  unused_pc_bits;

  // Counter increment that holds at the all-ones maximum
  function automatic logic [CTR_BITS-1:0] sat_inc_ctr(input logic [CTR_BITS-1:0] c);
    return (c == {CTR_BITS{1'b1}}) ? c : c + CTR_BITS'(1);
  endfunction

  // Counter decrement that holds at zero
  function automatic logic [CTR_BITS-1:0] sat_dec_ctr(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  // Statistics increment that holds at 16'hFFFF instead of wrapping
  function automatic logic [15:0] sat_inc_stat(input logic [15:0] s);
    return (s == 16'hFFFF) ? s : s + 16'd1;
  endfunction

  assign lookup_idx     = predict_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{predict_pc[PC_WIDTH-1:INDEX_BITS+2], predict_pc[1:0]};

  // No bypass: a same-cycle update to this index shows up from the next cycle
  assign predict_take = ctr_tab[lookup_idx][CTR_BITS-1];

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(QDEPTH));
  assign pop       = feedback_valid & ~empty;
  assign head_idx  = q_idx[head];
  assign head_pred = q_pred[head];

  assign feedback_mispredict = pop & (head_pred != feedback_take);
  assign predict_ready       = ~full | pop;

  // Younger entries after a mispredict are wrong-path, so pushes that cycle are dropped too
  assign discard = flush | feedback_mispredict;
  assign push    = predict_valid & predict_ready & ~discard;

  assign inflight_count = count;

  // Queue pointers and occupancy; a discard restarts the queue at slot zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (discard) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue payload writes; slots are only read while occupied, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[tail]  <= lookup_idx;
      q_pred[tail] <= predict_take;
    end
  end

  // Train the head entry's counter with the resolved outcome
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr_tab[i] <= CTR_BITS'(INIT_CTR);
    end else if (pop) begin
      ctr_tab[head_idx] <= feedback_take ? sat_inc_ctr(ctr_tab[head_idx])
                                         : sat_dec_ctr(ctr_tab[head_idx]);
    end
  end

  // Hit/miss statistics and sticky protocol error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count     <= '0;
      miss_count    <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (pop && !feedback_mispredict) hit_count  <= sat_inc_stat(hit_count);
      if (feedback_mispredict)         miss_count <= sat_inc_stat(miss_count);
      if (predict_valid && !predict_ready) err_overflow  <= 1'b1;
      if (feedback_valid && empty)         err_underflow <= 1'b1;
    end
  end

endmodule
